// File: rtl/rv_barrier_unit_if.sv
// rv_barrier_unit_if: warp-control commit bus into the barrier unit and its scheduler-facing results
// Ports (signals):
//   warp_ctl_valid, warp_ctl_wid, warp_ctl_barrier_valid, warp_ctl_barrier_id,
//   warp_ctl_barrier_size_m1   : commit from the execute unit (master drives)
//   stalled_warps, release_valid, release_id, release_mask, barrier_busy, err
//                              : barrier state results (slave drives)
interface rv_barrier_unit_if #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4
);
  localparam int NW_BITS = NUM_WARPS > 1 ? $clog2(NUM_WARPS) : 1;
  localparam int NB_BITS = NUM_BARRIERS > 1 ? $clog2(NUM_BARRIERS) : 1;
  logic                    warp_ctl_valid;
  logic [NW_BITS-1:0]      warp_ctl_wid;
  logic                    warp_ctl_barrier_valid;
  logic [NB_BITS-1:0]      warp_ctl_barrier_id;
  logic [NW_BITS-1:0]      warp_ctl_barrier_size_m1;
  logic [NUM_WARPS-1:0]    stalled_warps;
  logic                    release_valid;
  logic [NB_BITS-1:0]      release_id;
  logic [NUM_WARPS-1:0]    release_mask;
  logic [NUM_BARRIERS-1:0] barrier_busy;
  logic                    err;
  modport master (
    output warp_ctl_valid, warp_ctl_wid, warp_ctl_barrier_valid, warp_ctl_barrier_id, warp_ctl_barrier_size_m1,
    input  stalled_warps, release_valid, release_id, release_mask, barrier_busy, err
  );
  modport slave (
    input  warp_ctl_valid, warp_ctl_wid, warp_ctl_barrier_valid, warp_ctl_barrier_id, warp_ctl_barrier_size_m1,
    output stalled_warps, release_valid, release_id, release_mask, barrier_busy, err
  );
endinterface

// File: rtl/rv_barrier_unit.sv
// rv_barrier_unit: warp-barrier table tracking arrivals per barrier ID and releasing waiters together
// Ports:
//   clk    : core clock, all state on rising edge
//   reset  : synchronous active-low reset
//   bif    : rv_barrier_unit_if.slave (warp-control commit in; stall mask, release pulse, busy, err out)
// Optional feature: define RV_BARRIER_ERR_EN to enable the sticky protocol error flag.
module rv_barrier_unit #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4
) (
  input  logic          clk,
  input  logic          reset,
  rv_barrier_unit_if.slave bif
);
  localparam int NW_BITS = NUM_WARPS > 1 ? $clog2(NUM_WARPS) : 1;
  localparam int NB_BITS = NUM_BARRIERS > 1 ? $clog2(NUM_BARRIERS) : 1;
  logic [NW_BITS-1:0]      count_q [NUM_BARRIERS];
  logic [NW_BITS-1:0]      count_d [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]    wmask_q [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]    wmask_d [NUM_BARRIERS];
  logic [NW_BITS-1:0]      size_q  [NUM_BARRIERS];
  logic [NW_BITS-1:0]      size_d  [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]    stalled_q, stalled_d;
  logic                    rel_v_q, rel_v_d;
  logic [NB_BITS-1:0]      rel_id_q, rel_id_d;
  logic [NUM_WARPS-1:0]    rel_mask_q, rel_mask_d;
  logic [NUM_BARRIERS-1:0] busy_q, busy_d;
  logic                    arr;
  logic [NB_BITS-1:0]      b;
  logic [NW_BITS-1:0]      w;
  logic [NUM_WARPS-1:0]    wbit;
  logic [NW_BITS-1:0]      eff;
  assign arr  = bif.warp_ctl_valid & bif.warp_ctl_barrier_valid;
  assign b    = bif.warp_ctl_barrier_id;
  assign w    = bif.warp_ctl_wid;
  assign wbit = NUM_WARPS'(1) << w;
  assign eff  = count_q[b] == '0 ? bif.warp_ctl_barrier_size_m1 : size_q[b];
  // A warp already stalled is either a duplicate on this barrier or waiting on
  // another one; both are protocol violations and leave the table untouched.
  always_comb begin
    count_d    = count_q;
    wmask_d    = wmask_q;
    size_d     = size_q;
    stalled_d  = stalled_q;
    rel_v_d    = 1'b0;
    rel_id_d   = rel_id_q;
    rel_mask_d = rel_mask_q;
    if (arr && !stalled_q[w]) begin
      if (count_q[b] == eff) begin
        count_d[b] = '0;
        wmask_d[b] = '0;
        rel_v_d    = 1'b1;
        rel_id_d   = b;
        rel_mask_d = wmask_q[b] | wbit;
        stalled_d  = stalled_q & ~(wmask_q[b] | wbit);
      end else begin
        count_d[b] = NW_BITS'(count_q[b] + 1'b1);
        wmask_d[b] = wmask_q[b] | wbit;
        stalled_d  = stalled_q | wbit;
        size_d[b]  = count_q[b] == '0 ? bif.warp_ctl_barrier_size_m1 : size_q[b];
      end
    end
    for (int i = 0; i < NUM_BARRIERS; i++) busy_d[i] = count_d[i] != '0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_BARRIERS; i++) begin
        count_q[i] <= '0;
        wmask_q[i] <= '0;
        size_q[i]  <= '0;
      end
      stalled_q  <= '0;
      rel_v_q    <= 1'b0;
      rel_id_q   <= '0;
      rel_mask_q <= '0;
      busy_q     <= '0;
    end else begin
      count_q    <= count_d;
      wmask_q    <= wmask_d;
      size_q     <= size_d;
      stalled_q  <= stalled_d;
      rel_v_q    <= rel_v_d;
      rel_id_q   <= rel_id_d;
      rel_mask_q <= rel_mask_d;
      busy_q     <= busy_d;
    end
  end
  assign bif.stalled_warps = stalled_q;
  assign bif.release_valid = rel_v_q;
  assign bif.release_id    = rel_id_q;
  assign bif.release_mask  = rel_mask_q;
  assign bif.barrier_busy  = busy_q;
`ifdef RV_BARRIER_ERR_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (!reset) err_q <= 1'b0;
    else if (arr && (stalled_q[w] || (count_q[b] != '0 && bif.warp_ctl_barrier_size_m1 != size_q[b]))) err_q <= 1'b1;
  end
  assign bif.err = err_q;
`else
  assign bif.err = 1'b0;
`endif
endmodule
